pulse_sync_mc: RTL
==================

# pulse_sync_mc

Multi-channel pulse/level synchroniser and event conditioner for asynchronous inputs entering a single clock domain. Each channel passes through a configurable-depth flop synchroniser and a minimum-width glitch filter. A selectable edge detector then emits one-cycle pulses. Per-channel saturating event counters record those pulses. It replaces single-channel pulse synchronisers wherever several asynchronous strobes, buttons or handshake lines land in one clock domain.

## Interface
- CH, 4, number of independent channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)
- FILT, 2, consecutive cycles a new synchronised value must hold before acceptance (≥1; 1 = no filtering)
- CNT_W, 8, event counter width per channel (≥1)

- clk  in  1  sole clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- pulse_in  in  CH  asynchronous inputs, one bit per channel
- mode  in  2  edge select, all channels: 00 rise, 01 fall, 10 both, 11 detect disabled
- cnt_clr  in  1  synchronous clear of all counters and overflow flags
- dout  out  CH  one-cycle event pulse per channel
- level  out  CH  filtered, synchronised level per channel
- cnt  out  CH*CNT_W  event counts, channel i at [i*CNT_W +: CNT_W]
- ovf  out  CH  sticky flag: channel counter has saturated

## Operation
- Reset (rst=1 at an edge): synchroniser flops, filter counters, level, dout, cnt and ovf all go to 0. Any in-flight transition is discarded.
- Synchroniser: shift chain sync[0..SYNC_STAGES-1]. sync[0] <= pulse_in. Call the last stage s.
- Filter, per channel, with counter f (width clog2(FILT), min 1):
  - s == level: f <= 0.
  - s != level and f < FILT-1: f <= f+1.
  - s != level and f == FILT-1: level <= s, f <= 0, and a transition is flagged.
- Edge qualify: on a transition, dout <= 1 for one cycle when one of these holds:
  - rise: mode=00 and new level=1
  - fall: mode=01 and new level=0
  - either edge: mode=10
  
  Otherwise dout <= 0. With mode=11, level still tracks but dout stays 0.
- mode is sampled in the transition cycle. Changing mode never creates or removes an event retroactively.
- Counter: when dout is registered high, cnt_i <= cnt_i+1.
  - At 2^CNT_W-1 the counter holds its value and ovf_i <= 1.
  - ovf is sticky until cnt_clr or rst.
- cnt_clr: all cnt <= 0 and all ovf <= 0 at that edge. If it coincides with an event, clear wins and that event is not counted. dout itself is unaffected by cnt_clr.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulse and count.

## Timing
- Let E0 be the first edge at which sync[0] captures a new stable input value.
- level and dout update at edge E0 + (SYNC_STAGES-1) + FILT. Defaults give E0+3.
- Asynchronous sampling adds 0–1 cycle uncertainty relative to the input change.
- cnt updates one edge after dout is high, i.e. it lags dout by one cycle.
- A glitch whose value persists at s for fewer than FILT consecutive cycles is rejected: no level change, no dout.
- For both edges to be reported, an input pulse must stay at each level for at least FILT cycles plus one sampling cycle.
- Minimum spacing between same-channel dout pulses is FILT cycles.
- An input held high through reset release produces a rise transition at E0 = first edge after release. It reports if mode=00 or 10, because level restarts at 0.
- Reset mid-operation aborts pending filter counts. No dout is emitted for an input change that was in flight during reset.

## Test plan
All scenarios use CH=4, SYNC_STAGES=2, FILT=2, CNT_W=4 unless noted.
- Reset/latency: hold rst 3 cycles, then mode=00. Raise pulse_in[0] 2 ns before edge k → dout[0]=1 for exactly one cycle after edge k+3. level[0]=1 from the same edge. cnt[0]=1 after edge k+4. All other outputs stay 0.
- Glitch reject: pulse_in[1] high for 1 cycle (≤1 cycle at s) → level[1] and dout[1] stay 0 and cnt unchanged. A 4-cycle pulse → one rise pulse.
- Modes: drive a 6-cycle high pulse on ch2 under each mode:
  - mode=00 → 1 pulse, on the rise
  - mode=01 → 1 pulse, on the fall
  - mode=10 → 2 pulses
  - mode=11 → 0 pulses, while level[2] still toggles
- Saturation/clear: 17 qualifying rises on ch3 → cnt[3]=15 and ovf[3]=1 from the 15th count onward. Assert cnt_clr in the same cycle as an 18th dout → cnt[3]=0, ovf[3]=0, and that event is not counted.
- Simultaneous/reset: rise all 4 channels on the same cycle → dout=4'b1111 in one cycle, each cnt=1. Then raise ch0 and assert rst 2 cycles later → no dout from it. With pulse_in[0] held high after release → exactly one rise pulse at release+3 edges.

Source files
------------

// File: rtl/pulse_sync_mc.sv
// Multi-channel asynchronous pulse/level synchroniser with glitch filter,
// selectable edge detector and saturating per-channel event counters.
module pulse_sync_mc #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT        = 2,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         pulse_in,
  input  logic [1:0]            mode,
  input  logic                  cnt_clr,
  output logic [CH-1:0]         dout,
  output logic [CH-1:0]         level,
  output logic [CH*CNT_W-1:0]   cnt,
  output logic [CH-1:0]         ovf
);

  localparam int             FW      = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [FW-1:0]  F_MAX   = FW'(FILT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic [FW-1:0]          f_q, f_d;
      logic                   level_q, level_d;
      logic                   dout_q, dout_d;
      logic [CNT_W-1:0]       cnt_q, cnt_d;
      logic                   ovf_q, ovf_d;
      logic                   s;

      assign s = sync_q[SYNC_STAGES-1];

      always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], pulse_in[gi]};
        f_d     = f_q;
        level_d = level_q;
        dout_d  = 1'b0;
        if (s == level_q) begin
          f_d = '0;
        end else if (f_q != F_MAX) begin
          f_d = f_q + FW'(1);
        end else begin
          // New value has held long enough: accept it and qualify the edge
          f_d     = '0;
          level_d = s;
          case (mode)
            2'b00:   dout_d = s;
            2'b01:   dout_d = ~s;
            2'b10:   dout_d = 1'b1;
            default: dout_d = 1'b0;
          endcase
        end
      end

      always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (cnt_clr) begin
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (dout_q) begin
          if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            // Flag saturation as soon as the counter reaches its ceiling
            if (cnt_q == CNT_MAX - CNT_W'(1)) ovf_d = 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q  <= '0;
          f_q     <= '0;
          level_q <= 1'b0;
          dout_q  <= 1'b0;
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
        end else begin
          sync_q  <= sync_d;
          f_q     <= f_d;
          level_q <= level_d;
          dout_q  <= dout_d;
          cnt_q   <= cnt_d;
          ovf_q   <= ovf_d;
        end
      end

      assign dout[gi]                  = dout_q;
      assign level[gi]                 = level_q;
      assign cnt[gi*CNT_W +: CNT_W]    = cnt_q;
      assign ovf[gi]                   = ovf_q;
    end
  endgenerate

endmodule
